// File: rtl/reg_file.sv
// 32 x 32 general-purpose register file: two combinational read ports and one
// synchronous write port. Register 0 has no storage and always reads zero.
module reg_file #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] rna,
   input  logic [ADDR_WIDTH-1:0] rnb,
   input  logic [ADDR_WIDTH-1:0] wn,
   input  logic [DATA_WIDTH-1:0] datain,
   input  logic                  wreg,
   output logic [DATA_WIDTH-1:0] qa,
   output logic [DATA_WIDTH-1:0] qb
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs_q [1:DEPTH-1];
   logic [DATA_WIDTH-1:0] regs_d [1:DEPTH-1];
   logic [DEPTH-1:1]      wr_en;

   // One-hot write decode; index 0 has no enable, so writes to it vanish.
   always_comb begin
      wr_en = '0;
      for (int i = 1; i < DEPTH; i++) begin
         wr_en[i] = wreg && (wn == ADDR_WIDTH'(i));
      end
   end

   always_comb begin
      for (int i = 1; i < DEPTH; i++) begin
         regs_d[i] = wr_en[i] ? datain : regs_q[i];
      end
   end

   // Reset wins over a simultaneous write.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 1; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         for (int i = 1; i < DEPTH; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   // Read muxes: no write-through bypass, index 0 falls through to zero.
   always_comb begin
      qa = '0;
      qb = '0;
      for (int i = 1; i < DEPTH; i++) begin
         if (rna == ADDR_WIDTH'(i)) qa = regs_q[i];
         if (rnb == ADDR_WIDTH'(i)) qb = regs_q[i];
      end
   end

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: directed cases plus a random write/read phase, checked
// against a behavioural register model through an expected-value queue.
module tb_reg_file;

   logic        clk;
   logic        reset;
   logic [4:0]  rna;
   logic [4:0]  rnb;
   logic [4:0]  wn;
   logic [31:0] datain;
   logic        wreg;
   logic [31:0] qa;
   logic [31:0] qb;

   logic [31:0] model [32];
   logic [31:0] exp_q [$];
   int          n_checks;
   int          n_errors;

   reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
      .clk    (clk),
      .reset  (reset),
      .rna    (rna),
      .rnb    (rnb),
      .wn     (wn),
      .datain (datain),
      .wreg   (wreg),
      .qa     (qa),
      .qb     (qb)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // driver: one clock edge with the given controls, model updated alongside
   task automatic drive_edge(input logic rst, input logic we, input logic [4:0] w,
                             input logic [31:0] d);
      reset  = rst;
      wreg   = we;
      wn     = w;
      datain = d;
      @(posedge clk);
      #1;
      if (rst) begin
         for (int i = 0; i < 32; i++) model[i] = '0;
      end else if (we && w != 5'd0) begin
         model[w] = d;
      end
      reset = 1'b0;
      wreg  = 1'b0;
   endtask

   // driver + scoreboard: set read indices, queue expectations, then compare
   task automatic read_pair(input string tag, input logic [4:0] a, input logic [4:0] b);
      logic [31:0] ea;
      logic [31:0] eb;
      rna = a;
      rnb = b;
      exp_q.push_back(model[a]);
      exp_q.push_back(model[b]);
      #1;
      ea = exp_q.pop_front();
      eb = exp_q.pop_front();
      check($sformatf("%s qa[%0d]", tag, a), qa, ea);
      check($sformatf("%s qb[%0d]", tag, b), qb, eb);
   endtask

   initial begin
      logic [4:0]  rw;
      logic [31:0] rd;
      logic        rwe;
      n_checks = 0;
      n_errors = 0;
      reset = 1'b0; wreg = 1'b0; wn = '0; datain = '0; rna = '0; rnb = '0;
      for (int i = 0; i < 32; i++) model[i] = '0;
      @(posedge clk);
      #1;

      // reset, then sweep both ports
      drive_edge(1'b1, 1'b0, 5'd0, 32'h0);
      for (int i = 0; i < 32; i++) read_pair("reset", 5'(i), 5'(31 - i));

      // basic writes
      drive_edge(1'b0, 1'b1, 5'd1, 32'hFFFFFFFF);
      read_pair("wr1", 5'd1, 5'd0);
      drive_edge(1'b0, 1'b1, 5'd2, 32'h0000F00F);
      read_pair("wr2", 5'd2, 5'd1);
      drive_edge(1'b0, 1'b1, 5'd3, 32'hFF00FF00);
      read_pair("wr3", 5'd3, 5'd2);
      drive_edge(1'b0, 1'b1, 5'd4, 32'hAA0000AA);
      read_pair("wr4", 5'd4, 5'd3);

      // write disabled
      drive_edge(1'b0, 1'b0, 5'd5, 32'hFFFFFFFF);
      read_pair("nowe", 5'd5, 5'd4);
      check("nowe_const", qa, 32'h0);

      // register 0 and dual read
      drive_edge(1'b0, 1'b1, 5'd0, 32'h12345678);
      read_pair("r0", 5'd0, 5'd3);
      check("r0_const", qa, 32'h0);
      check("r3_const", qb, 32'hFF00FF00);
      read_pair("r5r31", 5'd5, 5'd31);

      // reset priority over a simultaneous write
      drive_edge(1'b1, 1'b1, 5'd7, 32'hDEADBEEF);
      read_pair("rstpri", 5'd7, 5'd1);
      check("rstpri_r7", qa, 32'h0);
      check("rstpri_r1", qb, 32'h0);

      // read-during-write: old value before the edge, new value right after
      drive_edge(1'b0, 1'b1, 5'd6, 32'h0000AAAA);
      rna = 5'd6; rnb = 5'd6; wn = 5'd6; datain = 32'h00000055; wreg = 1'b1;
      #1;
      check("rdw_before_qa", qa, 32'h0000AAAA);
      check("rdw_before_qb", qb, 32'h0000AAAA);
      @(posedge clk);
      #1;
      model[6] = 32'h00000055;
      wreg = 1'b0;
      check("rdw_after_qa", qa, 32'h00000055);
      check("rdw_after_qb", qb, 32'h00000055);

      // overwrite on consecutive edges
      rna = 5'd1;
      drive_edge(1'b0, 1'b1, 5'd1, 32'h00000001);
      read_pair("ovw1", 5'd1, 5'd6);
      drive_edge(1'b0, 1'b1, 5'd1, 32'h80000000);
      read_pair("ovw2", 5'd1, 5'd2);
      check("ovw2_const", qa, 32'h80000000);

      // random writes and reads
      for (int n = 0; n < 300; n++) begin
         rw  = 5'($urandom_range(0, 31));
         rd  = $urandom;
         rwe = 1'($urandom_range(0, 3) != 0);
         drive_edge(1'b0, rwe, rw, rd);
         read_pair("rand", 5'($urandom_range(0, 31)), rw);
      end

      if (exp_q.size() != 0) check("exp_q_empty", 32'(exp_q.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- 32-entry x 32-bit general-purpose register file for the single-cycle CPU datapath.
- Two asynchronous (combinational) read ports feed ALU operands A and B; one synchronous write port is driven by the writeback stage.
- Register 0 is hardwired to zero, MIPS-style.

Parameters:
- DATA_WIDTH, 32, width of each register and of the data ports.
- ADDR_WIDTH, 5, register-index width; depth = 2**ADDR_WIDTH = 32 entries.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high; clears all registers.
- rna  input  ADDR_WIDTH  read-port A register index.
- rnb  input  ADDR_WIDTH  read-port B register index.
- wn  input  ADDR_WIDTH  write-port register index.
- datain  input  DATA_WIDTH  write data.
- wreg  input  1  write enable, active-high.
- qa  output  DATA_WIDTH  contents of register rna.
- qb  output  DATA_WIDTH  contents of register rnb.

Behaviour:
- Interface: one clock (clk). Reset (reset) is synchronous and active-high.
- Storage: registers 1..31, each DATA_WIDTH bits. Register 0 has no storage and always reads 0.
- Reset: on a rising clk edge with reset=1, registers 1..31 become 0.
  - Reset has priority over a simultaneous write; that write is dropped.
  - While reset is held, qa/qb read 0 for every index from the first reset edge onward.
  - Before the first reset edge, register contents are undefined. The bench must reset first.
- Write: on a rising clk edge with reset=0, wreg=1 and wn!=0, register[wn] <= datain.
  - wn=0 with wreg=1 is silently ignored; register 0 stays 0.
  - wreg=0 leaves all registers unchanged regardless of wn/datain.
- Read: qa = (rna==0) ? 0 : register[rna]; qb = (rnb==0) ? 0 : register[rnb].
  - Reads are purely combinational, zero-cycle latency, and change as soon as rna/rnb or the addressed register changes.
- Read-during-write (same index as wn in the same cycle): no write-through bypass.
  - Before the edge the output shows the old value.
  - After the edge the new value appears in the same delta as the register update.
- Both read ports may address the same register, or the register being written; results are independent and consistent.
- Width rules: no arithmetic. datain is stored verbatim, full DATA_WIDTH. Index inputs are used as unsigned full-range 0..31, with no out-of-range case.
- Outputs are never X after the first reset edge.
- Implementation form:
  - Explicit register array with per-entry enable decode (one-hot write decoder from wn gated by wreg).
  - Two 32:1 read multiplexers.
  - Synthesizable as flip-flops; no memory inference requirement.

Test Plan:
- Reset: hold reset=1 for one clk edge, then reset=0 -> qa=qb=0 for rna/rnb swept over 0..31.
- Basic writes, each over one clock edge with wreg=1, then set rna to the same index -> qa equals the written value:
  - wn=1, datain=32'hFFFFFFFF
  - wn=2, datain=32'h0000F00F
  - wn=3, datain=32'hFF00FF00
  - wn=4, datain=32'hAA0000AA
- Write disabled: wn=5, wreg=0, datain=32'hFFFFFFFF for one edge -> rna=5 gives qa=0.
- Register 0 and dual read:
  - wn=0, wreg=1, datain=32'h12345678 for one edge; then rna=0, rnb=3 -> qa=0, qb=32'hFF00FF00.
  - rna=5, rnb=31 -> qa=0, qb=0.
- Reset priority and read-during-write:
  - reset=1 and wreg=1, wn=7, datain=32'hDEADBEEF on the same edge -> after the edge rna=7 gives 0 and rna=1 gives 0.
  - Separately, with rna=wn=6, wreg=1, datain=32'h00000055 -> qa shows the old value before the edge and 32'h00000055 immediately after it.
- Overwrite: write wn=1 with 32'h00000001, then 32'h80000000 on consecutive edges -> qa (rna=1) tracks each value one edge later; other registers unchanged.
